pipe_skid_stage: RTL

Parametrised pipeline stage register with a valid/ready handshake, a two-entry skid buffer, stall (hold) and flush. It replaces plain enable/default-value pipeline flops between CPU stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Upstream can stream at full rate while downstream back-pressure is absorbed without a combinational ready path. Bubbles present `def_val` (for example a NOP encoding) on the data output.

---
 rtl/pipe_pkg.sv | 15 +
 rtl/pipe_skid_stage_if.sv | 13 +
 rtl/pipe_entry.sv | 41 ++++
 rtl/pipe_skid_stage.sv | 126 ++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers: occupancy encoding and
// the bubble value instantiating stages drive onto def_val.
package pipe_pkg;

    // Occupancy of a skid stage; the encoding doubles as the occ output.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

    // addi x0, x0, 0 -- the canonical NOP, shown on bubbles.
    localparam logic [31:0] PIPE_NOP = 32'h0000_0013;

endpackage

// File: rtl/pipe_skid_stage_if.sv
// One valid/ready channel. A beat transfers on a rising clock edge where
// valid and ready are both high; the master holds valid and data stable
// until that edge, and ready may be raised or dropped independently of valid.
interface pipe_skid_stage_if #(
    parameter int DW = 32
);
    logic          valid;
    logic [DW-1:0] data;
    logic          ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_entry.sv
// A single buffered entry: valid bit plus payload, with load and clear.
// Clear only drops the valid bit; the payload is left as it was.
module pipe_entry #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          ld_i,
    input  logic [DW-1:0] d_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o
);

    logic          valid_q;
    logic [DW-1:0] data_q;

    // Valid bit: clear wins over load so a flush can never leave a stale entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
        end else if (ld_i) begin
            valid_q <= 1'b1;
        end
    end

    // Payload register, written only on load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (ld_i && !clr_i) begin
            data_q <= d_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with a two-entry skid buffer, hold and flush.
// in_ready is a flop driven from the next occupancy, so downstream ready
// never reaches upstream ready combinationally.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int DW             = 32,
    parameter bit FLUSH_HOLD_PRI = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      hold_en,
    input  logic [DW-1:0]             def_val,
    pipe_skid_stage_if.slave          in_if,
    pipe_skid_stage_if.master         out_if,
    output logic [1:0]                occ
);

    occ_e          state_q, state_d;
    logic          in_ready_q;

    logic          main_valid, skid_valid;
    logic [DW-1:0] main_data, skid_data;
    logic          main_ld, main_clr, skid_ld, skid_clr;
    logic [DW-1:0] main_d;

    logic          flush_eff;
    logic          in_fire, out_fire;

    // With hold priority, a flush arriving under hold is ignored entirely.
    assign flush_eff = FLUSH_HOLD_PRI ? flush : (flush & ~hold_en);

    assign in_fire  = in_if.valid & in_ready_q & ~hold_en & ~flush;
    assign out_fire = main_valid & out_if.ready & ~hold_en & ~flush;

    // Occupancy state register and registered upstream ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= OCC_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != OCC_TWO);
        end
    end

    // Next occupancy and entry load/clear controls.
    always_comb begin
        state_d  = state_q;
        main_ld  = 1'b0;
        main_clr = 1'b0;
        main_d   = in_if.data;
        skid_ld  = 1'b0;
        skid_clr = 1'b0;
        if (flush_eff) begin
            state_d  = OCC_EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                OCC_EMPTY: begin
                    if (in_fire) begin
                        state_d = OCC_ONE;
                        main_ld = 1'b1;
                    end
                end
                OCC_ONE: begin
                    if (in_fire && out_fire) begin
                        main_ld = 1'b1;
                    end else if (in_fire) begin
                        state_d = OCC_TWO;
                        skid_ld = 1'b1;
                    end else if (out_fire) begin
                        state_d  = OCC_EMPTY;
                        main_clr = 1'b1;
                    end
                end
                OCC_TWO: begin
                    // in_ready is low here, so only the head can leave.
                    if (out_fire) begin
                        state_d  = OCC_ONE;
                        main_ld  = 1'b1;
                        main_d   = skid_data;
                        skid_clr = 1'b1;
                    end
                end
                default: begin
                    state_d  = OCC_EMPTY;
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    pipe_entry #(.DW(DW)) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (main_clr),
        .ld_i    (main_ld),
        .d_i     (main_d),
        .valid_o (main_valid),
        .data_o  (main_data)
    );

    pipe_entry #(.DW(DW)) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (skid_clr),
        .ld_i    (skid_ld),
        .d_i     (in_if.data),
        .valid_o (skid_valid),
        .data_o  (skid_data)
    );

    assign in_if.ready  = in_ready_q;
    assign out_if.valid = main_valid;
    assign out_if.data  = main_valid ? main_data : def_val;
    assign occ          = state_q;

    // skid_valid mirrors occ==2; kept as an observable for checkers.
    logic skid_valid_unused;
    assign skid_valid_unused = skid_valid;

endmodule
